// File: rtl/ops_pkg.sv
// Shared types and helpers for the output port scheduler and other
// 4-way schedulers.
package ops_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] src_id_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    function automatic int credit_w(input int credits);
        return $clog2(credits + 1);
    endfunction

    function automatic src_id_t oh2idx(input logic [NUM_REQ-1:0] oh);
        src_id_t idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = src_id_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: the first requester at or after
// ptr (mod 4) wins.
module rr_pick4
    import ops_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  src_id_t            ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);

    src_id_t idx;

    // Walk from lowest to highest priority so the highest one lands last.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + src_id_t'(k);
            if (req[idx]) gnt = 4'b0001 << idx;
        end
    end

endmodule

// File: rtl/output_port_scheduler.sv
// Packet-level round-robin, credit-gated output port scheduler.
// Define OPS_STATS_EN to add per-input saturating packet counters (pkt_cnt).
module output_port_scheduler
    import ops_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CREDITS = 4
`ifdef OPS_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      credit_return,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    output src_id_t                   out_src,
`ifdef OPS_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0]  pkt_cnt,
`endif
    output logic                      err_credit_ovf
);

    localparam int CW = credit_w(CREDITS);

    state_t             state, state_nxt;
    src_id_t            ptr, ptr_nxt;
    src_id_t            lock, lock_nxt;
    logic [CW-1:0]      credit_cnt;
    logic [NUM_REQ-1:0] gnt, ready;
    logic               any, has_cr, accept;
    src_id_t            sel;

    rr_pick4 u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .any (any)
    );

    assign has_cr = credit_cnt != '0;

    always_comb begin
        ready     = '0;
        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock;
        unique case (state)
            IDLE: begin
                if (any && has_cr) begin
                    ready = gnt;
                    if (|(req_last & gnt)) begin
                        ptr_nxt = oh2idx(gnt) + 2'd1;
                    end else begin
                        lock_nxt  = oh2idx(gnt);
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (req_valid[lock] && has_cr) begin
                    ready[lock] = 1'b1;
                    if (req_last[lock]) begin
                        ptr_nxt   = lock + 2'd1;
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    assign req_ready = rst ? ready : '0;
    assign accept    = |(req_valid & req_ready);
    assign sel       = oh2idx(req_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ptr            <= '0;
            lock           <= '0;
            credit_cnt     <= CW'(CREDITS);
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_last       <= 1'b0;
            out_src        <= '0;
            err_credit_ovf <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            lock      <= lock_nxt;
            out_valid <= accept;
            if (accept) begin
                out_data <= req_data[sel*DATA_W +: DATA_W];
                out_last <= req_last[sel];
                out_src  <= sel;
            end
            case ({accept, credit_return})
                2'b10: credit_cnt <= credit_cnt - 1'b1;
                2'b01: begin
                    if (credit_cnt == CW'(CREDITS)) err_credit_ovf <= 1'b1;
                    else credit_cnt <= credit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef OPS_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i] && req_last[i] && cnt[i] != '1)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign pkt_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: packet-queue sources, a per-cycle
// reference model, and directed scenarios with literal expectations.
module tb_output_port_scheduler;
    import ops_pkg::*;

    localparam int DW = 64;
    localparam int CR = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } flit_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      req_valid = '0;
    logic [4*DW-1:0] req_data = '0;
    logic [3:0]      req_last = '0;
    logic [3:0]      req_ready;
    logic            credit_return = 1'b0;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_src;
    logic            err_credit_ovf;
`ifdef OPS_STATS_EN
    logic [4*16-1:0] pkt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_port_scheduler #(.DATA_W(DW), .CREDITS(CR)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .credit_return  (credit_return),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_src        (out_src),
`ifdef OPS_STATS_EN
        .pkt_cnt        (pkt_cnt),
`endif
        .err_credit_ovf (err_credit_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: arbitration rules applied to a plain packet view.
    int            m_ptr, m_lock, m_cred, m_os, win;
    bit            m_locked, m_err, m_ov, m_ol;
    logic [DW-1:0] m_od;
    logic [3:0]    exp_rdy;
    int            src_log[$];

    always @(negedge clk) begin
        if (!rst) begin
            m_ptr = 0; m_lock = 0; m_locked = 0; m_cred = CR;
            m_err = 0; m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
        end
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_last", out_last, m_ol);
        chk("out_src", out_src, m_os);
        chk("err_credit_ovf", err_credit_ovf, m_err);
        if (out_valid) src_log.push_back(int'(out_src));
        win = -1;
        if (rst && m_cred > 0) begin
            if (m_locked) begin
                if (req_valid[m_lock]) win = m_lock;
            end else begin
                for (int k = 0; k < 4; k++)
                    if (win < 0 && req_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        if (rst) begin
            m_ov = (win >= 0);
            if (win >= 0) begin
                m_od = req_data[win*DW +: DW];
                m_ol = req_last[win];
                m_os = win;
                if (req_last[win]) begin
                    m_locked = 0;
                    m_ptr = (win + 1) % 4;
                end else begin
                    m_locked = 1;
                    m_lock = win;
                end
            end
            if (m_ov && !credit_return) m_cred--;
            else if (!m_ov && credit_return) begin
                if (m_cred == CR) m_err = 1;
                else m_cred++;
            end
        end
    end

    // Sources: one flit queue per input, popped on handshake.
    flit_t      q [4][$];
    logic [3:0] hold = '0;
    logic [3:0] fire;
    int         seq = 0;

    task automatic push(input int i, input int n);
        flit_t f;
        for (int k = 0; k < n; k++) begin
            f.d = (64'(i) << 56) | 64'(seq);
            f.l = (k == n - 1);
            seq++;
            q[i].push_back(f);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = q[i].size() > 0 && !hold[i];
            req_last[i] = req_valid[i] ? q[i][0].l : 1'b0;
            req_data[i*DW +: DW] = req_valid[i] ? q[i][0].d : '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1 fire = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (fire[i]) q[i].delete(0);
        credit_return = 1'b0;
        drive();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic give_credits(input int n);
        for (int k = 0; k < n; k++) begin
            credit_return = 1'b1;
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b0;
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 4'h0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err_credit_ovf, 0);
        req_valid = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        drive();

        // 1: four single-flit packets at once, then out of credits
        src_log.delete();
        for (int i = 0; i < 4; i++) push(i, 1);
        drive();
        ticks(6);
        chk("t1_count", src_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_order", src_log[i], i);

        // 3: no credits blocks everything; one return lets one flit through
        push(0, 1);
        drive();
        #1 chk("t3_blocked", req_ready, 4'h0);
        ticks(3);
        chk("t3_none", src_log.size(), 4);
        give_credits(1);
        ticks(3);
        chk("t3_one", src_log.size(), 5);
        chk("t3_src", src_log[4], 0);
        give_credits(4);

        // 2: 3-flit packet from input 1 holds off input 2
        src_log.delete();
        push(1, 3);
        push(2, 1);
        drive();
        #1 chk("t2_ready_head", req_ready, 4'b0010);
        tick();
        #1 chk("t2_ready_mid", req_ready, 4'b0010);
        ticks(5);
        chk("t2_count", src_log.size(), 4);
        chk("t2_s0", src_log[0], 1);
        chk("t2_s2", src_log[2], 1);
        chk("t2_s3", src_log[3], 2);
        give_credits(4);

        // 4: accept plus return in one cycle at 2 credits keeps 2
        src_log.delete();
        push(0, 1);
        push(0, 1);
        drive();
        ticks(3);
        push(1, 1);
        drive();
        credit_return = 1'b1;
        tick();
        ticks(2);
        push(2, 1); push(2, 1); push(2, 1);
        drive();
        ticks(6);
        chk("t4_count", src_log.size(), 5);
        give_credits(1);
        ticks(2);
        give_credits(4);
        chk("t4_err_before", err_credit_ovf, 0);
        give_credits(1);
        chk("t4_err_set", err_credit_ovf, 1);
        ticks(2);
        chk("t4_err_sticky", err_credit_ovf, 1);

        // 5: locked on input 3 with a two-cycle bubble
        src_log.delete();
        push(3, 2);
        drive();
        tick();
        hold[3] = 1'b1;
        push(0, 1);
        drive();
        #1 chk("t5_bubble_ready", req_ready, 4'h0);
        ticks(2);
        push(1, 1);
        hold[3] = 1'b0;
        drive();
        #1 chk("t5_tail_ready", req_ready, 4'b1000);
        ticks(5);
        chk("t5_count", src_log.size(), 4);
        chk("t5_s1", src_log[1], 3);
        chk("t5_s2", src_log[2], 0);
        chk("t5_s3", src_log[3], 1);
        give_credits(4);

        // 6: reset in the middle of a packet
        push(2, 3);
        drive();
        ticks(2);
        #2 rst = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_out_src", out_src, 0);
        chk("t6_ready", req_ready, 4'h0);
        chk("t6_err", err_credit_ovf, 0);
`ifdef OPS_STATS_EN
        chk("t6_pkt_cnt", pkt_cnt, 0);
`endif
        for (int i = 0; i < 4; i++) q[i].delete();
        drive();
        @(posedge clk);
        #1 rst = 1'b1;
        src_log.delete();
        for (int i = 0; i < 4; i++) push(i, 1);
        push(0, 1);
        drive();
        ticks(8);
        chk("t6_full_credits", src_log.size(), 4);
        chk("t6_exhausted", req_ready, 4'h0);

`ifdef OPS_STATS_EN
        for (int i = 0; i < 4; i++) q[i].delete();
        rst = 1'b0;
        drive();
        @(posedge clk);
        #1 rst = 1'b1;
        credit_return = 1'b1;
        req_valid = 4'b0001;
        req_last = 4'b0001;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_cnt0", pkt_cnt[15:0], 16'hFFFF);
        chk("sat_cnt1", pkt_cnt[31:16], 0);
        credit_return = 1'b0;
        req_valid = '0;
        req_last = '0;
        ticks(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
